// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module  : mc_ctrl_pkg
// Brief   : Shared encodings for the multicycle main controller: states,
//           op/cmd codes, ALU control codes and datapath mux selects.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic       ADR_PC    = 1'b0;
    localparam logic       ADR_ALU   = 1'b1;
    localparam logic       SRCA_RD1  = 1'b0;
    localparam logic       SRCA_PC   = 1'b1;
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_READ   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic is_pc(input logic [3:0] r);
        return (r == 4'd15);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
// ============================================================================
// Module  : mc_control_fsm_if
// Brief   : Instruction-field inputs and datapath control outputs of the
//           main controller. mem_ready exists only with MC_CTRL_MEMWAIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_control_fsm_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
`ifdef MC_CTRL_MEMWAIT_EN
    logic       mem_ready;
`endif
    logic       ir_write;
    logic       next_pc;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic [1:0] flag_w;
    logic       no_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_control;
    logic       illegal;

`ifdef MC_CTRL_MEMWAIT_EN
    modport master (
        input  op, funct, rd, mem_ready,
        output ir_write, next_pc, pcs, reg_w, mem_w, flag_w, no_write,
               adr_src, alu_src_a, alu_src_b, result_src, alu_control, illegal
    );
    modport slave (
        output op, funct, rd, mem_ready,
        input  ir_write, next_pc, pcs, reg_w, mem_w, flag_w, no_write,
               adr_src, alu_src_a, alu_src_b, result_src, alu_control, illegal
    );
`else
    modport master (
        input  op, funct, rd,
        output ir_write, next_pc, pcs, reg_w, mem_w, flag_w, no_write,
               adr_src, alu_src_a, alu_src_b, result_src, alu_control, illegal
    );
    modport slave (
        output op, funct, rd,
        input  ir_write, next_pc, pcs, reg_w, mem_w, flag_w, no_write,
               adr_src, alu_src_a, alu_src_b, result_src, alu_control, illegal
    );
`endif

endinterface

`default_nettype wire

// File: rtl/mc_control_fsm_alu_dec.sv
// ============================================================================
// Module  : alu_dec
// Brief   : Combinational data-processing command decoder: ALU control,
//           flag-write request, CMP register-write suppression, illegal cmd.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_dec
    import mc_ctrl_pkg::*;
(
    input  wire logic [4:0] funct,       // funct[4:0]; the I bit is not needed here
    input  wire logic       alu_op,
    output logic      [1:0] alu_control,
    output logic      [1:0] flag_w,
    output logic            no_write,
    output logic            cmd_illegal
);

    logic [3:0] cmd;
    logic       s_eff;
    logic       arith;

    assign cmd = funct[4:1];

    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        no_write    = 1'b0;
        cmd_illegal = 1'b0;
        s_eff       = funct[0];
        arith       = 1'b0;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: begin
                    alu_control = ALU_ADD;
                    arith       = 1'b1;
                end
                CMD_SUB: begin
                    alu_control = ALU_SUB;
                    arith       = 1'b1;
                end
                CMD_AND: alu_control = ALU_AND;
                CMD_ORR: alu_control = ALU_ORR;
                CMD_CMP: begin
                    alu_control = ALU_SUB;
                    arith       = 1'b1;
                    no_write    = 1'b1;
                    s_eff       = 1'b1;
                end
                default: cmd_illegal = 1'b1;
            endcase
            // Unsupported commands run as ADD but must never touch the flags
            if (!cmd_illegal) begin
                flag_w = {s_eff, s_eff & arith};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module  : mc_control_fsm
// Brief   : Multicycle main controller (FETCH/DECODE/EXECUTE/WRITEBACK).
//           MC_CTRL_MEMWAIT_EN adds mem_ready stalls in FETCH/MEMRD/MEMWR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    mc_control_fsm_if.master bus
);

    state_t     state;
    state_t     next_state;

    logic       mem_rdy;
    logic       dec_op;
    logic [1:0] dec_alu_control;
    logic [1:0] dec_flag_w;
    logic       dec_no_write;
    logic       dec_illegal;

    logic       ir_write_s;
    logic       next_pc_s;
    logic       pcs_s;
    logic       reg_w_s;
    logic       mem_w_s;
    logic [1:0] flag_w_s;
    logic       no_write_s;
    logic       adr_src_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_control_s;
    logic       illegal_s;

`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_rdy = bus.mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // The decoder is live from DECODE through ALUWB so no_write and the
    // illegal-cmd flag stay valid for the whole data-processing sequence.
    assign dec_op = (bus.op == OP_DP) &&
                    ((state == S_DECODE) || (state == S_EXECR) ||
                     (state == S_EXECI)  || (state == S_ALUWB));

    alu_dec u_alu_dec (
        .funct       (bus.funct[4:0]),
        .alu_op      (dec_op),
        .alu_control (dec_alu_control),
        .flag_w      (dec_flag_w),
        .no_write    (dec_no_write),
        .cmd_illegal (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        ir_write_s    = 1'b0;
        next_pc_s     = 1'b0;
        pcs_s         = 1'b0;
        reg_w_s       = 1'b0;
        mem_w_s       = 1'b0;
        flag_w_s      = 2'b00;
        no_write_s    = 1'b0;
        illegal_s     = 1'b0;
        adr_src_s     = ADR_PC;
        alu_src_a_s   = SRCA_PC;
        alu_src_b_s   = SRCB_FOUR;
        result_src_s  = RES_ALU;
        alu_control_s = ALU_ADD;

        case (state)
            S_FETCH: begin
                ir_write_s = mem_rdy;
                next_pc_s  = mem_rdy;
                if (mem_rdy) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                no_write_s = dec_no_write;
                illegal_s  = (bus.op == OP_ILL) || dec_illegal;
                case (bus.op)
                    OP_DP:   next_state = bus.funct[5] ? S_EXECI : S_EXECR;
                    OP_MEM:  next_state = S_MEMADR;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_EXECR, S_EXECI: begin
                alu_src_a_s   = SRCA_RD1;
                alu_src_b_s   = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                alu_control_s = dec_alu_control;
                flag_w_s      = dec_flag_w;
                no_write_s    = dec_no_write;
                next_state    = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_s = RES_ALUOUT;
                reg_w_s      = !dec_illegal;
                pcs_s        = is_pc(bus.rd);
                no_write_s   = dec_no_write;
                next_state   = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_IMM;
                next_state  = bus.funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src_s    = ADR_ALU;
                result_src_s = RES_ALUOUT;
                if (mem_rdy) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src_s = RES_READ;
                reg_w_s      = 1'b1;
                pcs_s        = is_pc(bus.rd);
                next_state   = S_FETCH;
            end
            S_MEMWR: begin
                adr_src_s = ADR_ALU;
                mem_w_s   = 1'b1;
                if (mem_rdy) begin
                    next_state = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_IMM;
                pcs_s       = 1'b1;
                next_state  = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Reset forces the state to FETCH asynchronously; the write enables are
    // also masked directly so FETCH's ir_write/next_pc cannot fire in reset.
    assign bus.ir_write    = ir_write_s & ~reset;
    assign bus.next_pc     = next_pc_s  & ~reset;
    assign bus.pcs         = pcs_s      & ~reset;
    assign bus.reg_w       = reg_w_s    & ~reset;
    assign bus.mem_w       = mem_w_s    & ~reset;
    assign bus.flag_w      = flag_w_s   & {2{~reset}};
    assign bus.no_write    = no_write_s;
    assign bus.illegal     = illegal_s;
    assign bus.adr_src     = adr_src_s;
    assign bus.alu_src_a   = alu_src_a_s;
    assign bus.alu_src_b   = alu_src_b_s;
    assign bus.result_src  = result_src_s;
    assign bus.alu_control = alu_control_s;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module  : tb_mc_control_fsm
// Brief   : Directed per-cycle checks of the main controller's outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mc_control_fsm_if bus_if ();

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // {ir_write, next_pc, pcs, reg_w, mem_w, flag_w, no_write, adr_src,
    //  alu_src_a, alu_src_b, result_src, alu_control, illegal}
    logic [16:0] outs;
    assign outs = {bus_if.ir_write, bus_if.next_pc, bus_if.pcs, bus_if.reg_w,
                   bus_if.mem_w, bus_if.flag_w, bus_if.no_write, bus_if.adr_src,
                   bus_if.alu_src_a, bus_if.alu_src_b, bus_if.result_src,
                   bus_if.alu_control, bus_if.illegal};

    localparam logic [16:0] K_WE  = 17'b11111_11_0_0_0_00_00_00_1;
    localparam logic [16:0] K_NW  = 17'b00000_00_1_0_0_00_00_00_0;
    localparam logic [16:0] K_ADR = 17'b00000_00_0_1_0_00_00_00_0;
    localparam logic [16:0] K_SA  = 17'b00000_00_0_0_1_00_00_00_0;
    localparam logic [16:0] K_SB  = 17'b00000_00_0_0_0_11_00_00_0;
    localparam logic [16:0] K_RS  = 17'b00000_00_0_0_0_00_11_00_0;
    localparam logic [16:0] K_AC  = 17'b00000_00_0_0_0_00_00_11_0;

    localparam logic [16:0] M_FETCH  = K_WE | K_ADR | K_SA | K_SB | K_RS | K_AC;
    localparam logic [16:0] M_DEC    = K_WE | K_SA | K_SB | K_RS | K_NW;
    localparam logic [16:0] M_EXEC   = K_WE | K_SA | K_SB | K_AC | K_NW;
    localparam logic [16:0] M_ALUWB  = K_WE | K_RS | K_NW;
    localparam logic [16:0] M_MEMADR = K_WE | K_SA | K_SB | K_AC;
    localparam logic [16:0] M_MEMRD  = K_WE | K_ADR | K_RS;
    localparam logic [16:0] M_MEMWB  = K_WE | K_RS;
    localparam logic [16:0] M_MEMWR  = K_WE | K_ADR;
    localparam logic [16:0] M_BR     = K_WE | K_SA | K_SB | K_RS | K_AC;

    function automatic logic [16:0] f(
        input logic ir, np, pcs, rw, mw, input logic [1:0] fw,
        input logic nw, adr, sa, input logic [1:0] sb, rs, ac, input logic ill);
        return {ir, np, pcs, rw, mw, fw, nw, adr, sa, sb, rs, ac, ill};
    endfunction

    function automatic logic [16:0] e_fetch();
        return f(1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0);
    endfunction

    // FETCH selects with every write enable low (reset or memory stall)
    function automatic logic [16:0] e_idle();
        return f(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0);
    endfunction

    function automatic logic [16:0] e_decode(input logic nw, input logic ill);
        return f(0, 0, 0, 0, 0, 2'b00, nw, 0, 1, 2'b10, 2'b10, 2'b00, ill);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_now(input string tag, input logic [16:0] exp, input logic [16:0] msk);
        check(tag, {15'd0, outs & msk}, {15'd0, exp & msk});
    endtask

    task automatic cyc(input string tag, input logic [16:0] exp, input logic [16:0] msk);
        chk_now(tag, exp, msk);
        @(negedge clk);
        #1;
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        bus_if.op    = op;
        bus_if.funct = funct;
        bus_if.rd    = rd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        reset  = 1'b1;
        instr(2'b00, 6'b001000, 4'd1);
`ifdef MC_CTRL_MEMWAIT_EN
        bus_if.mem_ready = 1'b1;
`endif
        #2;
        chk_now("reset_early", e_idle(), M_FETCH);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_now("reset_held", e_idle(), M_FETCH);
        reset = 1'b0;
        #1;

        // ADD r1, register operand
        instr(2'b00, 6'b001000, 4'd1);
        cyc("add_fetch",  e_fetch(), M_FETCH);
        cyc("add_decode", e_decode(0, 0), M_DEC);
        cyc("add_execr",  f(0,0,0,0,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_EXEC);
        cyc("add_aluwb",  f(0,0,0,1,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_ALUWB);

        // SUBS r2, immediate
        instr(2'b00, 6'b100101, 4'd2);
        cyc("subs_fetch",  e_fetch(), M_FETCH);
        cyc("subs_decode", e_decode(0, 0), M_DEC);
        cyc("subs_execi",  f(0,0,0,0,0,2'b11,0,0,0,2'b01,2'b00,2'b01,0), M_EXEC);
        cyc("subs_aluwb",  f(0,0,0,1,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_ALUWB);

        // CMP, register operand
        instr(2'b00, 6'b010101, 4'd0);
        cyc("cmp_fetch",  e_fetch(), M_FETCH);
        cyc("cmp_decode", e_decode(1, 0), M_DEC);
        cyc("cmp_execr",  f(0,0,0,0,0,2'b11,1,0,0,2'b00,2'b00,2'b01,0), M_EXEC);
        cyc("cmp_aluwb",  f(0,0,0,1,0,2'b00,1,0,0,2'b00,2'b00,2'b00,0), M_ALUWB);

        // ANDS r4: logical op with S updates NZ only
        instr(2'b00, 6'b000001, 4'd4);
        cyc("ands_fetch",  e_fetch(), M_FETCH);
        cyc("ands_decode", e_decode(0, 0), M_DEC);
        cyc("ands_execr",  f(0,0,0,0,0,2'b10,0,0,0,2'b00,2'b00,2'b10,0), M_EXEC);
        cyc("ands_aluwb",  f(0,0,0,1,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_ALUWB);

        // ORR r15: writes the PC
        instr(2'b00, 6'b011000, 4'd15);
        cyc("orr_fetch",  e_fetch(), M_FETCH);
        cyc("orr_decode", e_decode(0, 0), M_DEC);
        cyc("orr_execr",  f(0,0,0,0,0,2'b00,0,0,0,2'b00,2'b00,2'b11,0), M_EXEC);
        cyc("orr_aluwb",  f(0,0,1,1,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_ALUWB);

        // Unsupported cmd 0001 with S: ADD, no flag or register write
        instr(2'b00, 6'b000011, 4'd1);
        cyc("badcmd_fetch",  e_fetch(), M_FETCH);
        cyc("badcmd_decode", e_decode(0, 1), M_DEC);
        cyc("badcmd_execr",  f(0,0,0,0,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_EXEC);
        cyc("badcmd_aluwb",  f(0,0,0,0,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_ALUWB);

        // LDR r15: 5 cycles
        instr(2'b01, 6'b011001, 4'd15);
        cyc("ldr_fetch",  e_fetch(), M_FETCH);
        cyc("ldr_decode", e_decode(0, 0), M_DEC);
        cyc("ldr_memadr", f(0,0,0,0,0,2'b00,0,0,0,2'b01,2'b00,2'b00,0), M_MEMADR);
        cyc("ldr_memrd",  f(0,0,0,0,0,2'b00,0,1,0,2'b00,2'b00,2'b00,0), M_MEMRD);
        cyc("ldr_memwb",  f(0,0,1,1,0,2'b00,0,0,0,2'b00,2'b01,2'b00,0), M_MEMWB);

        // STR r3: 4 cycles, one mem_w pulse
        instr(2'b01, 6'b011000, 4'd3);
        cyc("str_fetch",  e_fetch(), M_FETCH);
        cyc("str_decode", e_decode(0, 0), M_DEC);
        cyc("str_memadr", f(0,0,0,0,0,2'b00,0,0,0,2'b01,2'b00,2'b00,0), M_MEMADR);
        cyc("str_memwr",  f(0,0,0,0,1,2'b00,0,1,0,2'b00,2'b00,2'b00,0), M_MEMWR);

        // B: 3 cycles
        instr(2'b10, 6'b101000, 4'd0);
        cyc("b_fetch",  e_fetch(), M_FETCH);
        cyc("b_decode", e_decode(0, 0), M_DEC);
        cyc("b_branch", f(0,0,1,0,0,2'b00,0,0,0,2'b01,2'b10,2'b00,0), M_BR);

        // Illegal op11: 2 cycles, no writes
        instr(2'b11, 6'b001000, 4'd15);
        cyc("ill_fetch",  e_fetch(), M_FETCH);
        cyc("ill_decode", e_decode(0, 1), M_DEC);

        // Reset rising during ALUWB
        instr(2'b00, 6'b001000, 4'd15);
        cyc("rst_fetch",  e_fetch(), M_FETCH);
        cyc("rst_decode", e_decode(0, 0), M_DEC);
        cyc("rst_execr",  f(0,0,0,0,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_EXEC);
        chk_now("rst_aluwb_pre", f(0,0,1,1,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_ALUWB);
        reset = 1'b1;
        #1;
        chk_now("rst_aluwb_drop", e_idle(), M_FETCH);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        instr(2'b00, 6'b001000, 4'd1);
        cyc("post_rst_fetch",  e_fetch(), M_FETCH);
        cyc("post_rst_decode", e_decode(0, 0), M_DEC);
        cyc("post_rst_execr",  f(0,0,0,0,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_EXEC);
        cyc("post_rst_aluwb",  f(0,0,0,1,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_ALUWB);

`ifdef MC_CTRL_MEMWAIT_EN
        // Three stalled FETCH cycles, then exactly one ir_write pulse
        instr(2'b00, 6'b001000, 4'd1);
        bus_if.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("wait_fetch_stall", e_idle(), M_FETCH);
        end
        bus_if.mem_ready = 1'b1;
        cyc("wait_fetch_go",  e_fetch(), M_FETCH);
        cyc("wait_decode",    e_decode(0, 0), M_DEC);
        cyc("wait_execr",     f(0,0,0,0,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_EXEC);
        cyc("wait_aluwb",     f(0,0,0,1,0,2'b00,0,0,0,2'b00,2'b00,2'b00,0), M_ALUWB);
`endif

        chk_now("final_fetch", e_fetch(), M_FETCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
